stft_sample_feeder: RTL
=======================

// Module: stft_sample_feeder
// PURPOSE
// - Producer/initiator side of the STFT engine handshake. Takes audio samples from the
//   ADC front end and stores them in a FFT_SIZE-deep circular sample RAM.
// - Per sample, presents the new sample and the oldest sample (the one being overwritten)
//   to the STFT engine, pulses start_compute, then waits for compute_done before accepting more.
// - Sits between the ADC capture block and the STFT update state machine.
// PARAMETERS
// - WORD_WIDTH    16     sample width, bits (two's complement)
// - FFT_SIZE      512    circular buffer depth; power of two, >= 4
// - DONE_TIMEOUT  1024   max WAIT_DONE cycles before abort; must be > FFT_SIZE+4
// PORTS
// - clk            in   1                 clock, all logic on rising edge
// - reset          in   1                 synchronous, active-high
// - in_valid       in   1                 one-cycle strobe: in_sample is valid
// - in_sample      in   WORD_WIDTH        new audio sample
// - in_ready       out  1                 registered; 1 only in IDLE
// - start_compute  out  1                 one-cycle pulse to STFT engine
// - sample         out  WORD_WIDTH        newest sample, stable from START until next WRITE
// - oldest_sample  out  WORD_WIDTH        sample being overwritten, same stability as sample
// - compute_done   in   1                 one-cycle pulse from STFT engine: bin sweep finished
// - wr_ptr         out  $clog2(FFT_SIZE)  buffer slot that the next sample will occupy
// - primed         out  1                 sticky; 1 once FFT_SIZE samples have been written
// - overrun_count  out  16                saturating count of dropped in_valid strobes
// - timeout_err    out  1                 sticky; set on compute_done timeout
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1 on the first cycle after reset, start_compute=0,
//   sample=0, oldest_sample=0, wr_ptr=0, primed=0, overrun_count=0, timeout_err=0,
//   timeout counter=0. Sample RAM contents are not reset.
// - Reset mid-operation aborts any state and returns to IDLE. No start_compute is issued.
// - Sample RAM: single port, 1-cycle synchronous read, write-on-edge.
// - State machine (T = accept cycle):
//   IDLE     : in_valid=1 -> latch in_sample, go to READ at T+1.
//   READ     : RAM address = wr_ptr, read issued (T+1).
//   WRITE    : oldest_sample <= primed ? ram_q : 0. sample <= latched sample.
//              RAM[wr_ptr] <= latched sample (T+2).
//   START    : start_compute=1 for exactly this cycle (T+3). Clear timeout counter.
//   WAIT_DONE: from T+4, until compute_done=1. Then wr_ptr <= wr_ptr+1 (wraps FFT_SIZE-1 -> 0).
//              primed <= 1 if wr_ptr was FFT_SIZE-1. Next state IDLE.
// - Minimum sample period: 5 cycles (compute_done at T+4 -> IDLE at T+5).
// - compute_done is sampled only in WAIT_DONE. It is ignored in every other state.
// - Timeout: in WAIT_DONE the counter increments each cycle. At DONE_TIMEOUT cycles:
//   - set timeout_err, advance wr_ptr as if done, return to IDLE.
//   - compute_done arriving in the same cycle counts as a normal completion; no error.
// - Drops: in_valid=1 while in_ready=0 means the sample is discarded and overrun_count
//   increments (saturates at 16'hFFFF). This includes the cycle of compute_done in WAIT_DONE.
// - Before primed: oldest_sample is forced to 0. The sliding update then behaves as if the
//   window were zero-filled.
// - in_valid and start_compute never coincide in effect: in_ready is 0 from READ through WAIT_DONE.
// TESTING
// - Reset, then in_valid with in_sample=16'h0123 at T -> start_compute=1 only at T+3.
//   At T+3: sample=16'h0123, oldest_sample=0. compute_done at T+6 -> in_ready=1 and wr_ptr=1 at T+7.
// - Write 512 samples of value n+1 (n = 0..511), each acked by compute_done:
//   - primed rises after sample 512; wr_ptr wraps to 0.
//   - sample 513 = 16'hAAAA gives oldest_sample=16'h0001.
// - Strobe in_valid 3 times during WAIT_DONE, once coincident with compute_done
//   -> overrun_count=3, none written to RAM.
// - Hold off compute_done -> timeout_err=1 after 1024 WAIT_DONE cycles, in_ready=1 next cycle,
//   wr_ptr advanced. Repeat with compute_done on the expiry cycle -> timeout_err stays 0.
// - Assert reset during WAIT_DONE after 200 samples -> all outputs at reset values next cycle.
//   The next sample reports oldest_sample=0.
// - compute_done pulsed while in IDLE and START -> no state change, no wr_ptr change.

Source files
------------

// File: rtl/stft_sample_feeder.sv
// stft_sample_feeder: accepts ADC samples into a circular sample RAM and, per sample,
// hands the newest and the displaced (oldest) sample to the STFT engine, then waits
// for the engine's completion pulse (or a timeout) before accepting the next one.
module stft_sample_feeder #(
  parameter int WORD_WIDTH   = 16,
  parameter int FFT_SIZE     = 512,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic signed [WORD_WIDTH-1:0]  in_sample,
  output logic                          in_ready,
  output logic                          start_compute,
  output logic signed [WORD_WIDTH-1:0]  sample,
  output logic signed [WORD_WIDTH-1:0]  oldest_sample,
  input  logic                          compute_done,
  output logic [$clog2(FFT_SIZE)-1:0]   wr_ptr,
  output logic                          primed,
  output logic [15:0]                   overrun_count,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(FFT_SIZE);
  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_START,
    S_WAIT_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic                         in_ready_q, in_ready_d;
  logic                         start_q, start_d;
  logic signed [WORD_WIDTH-1:0] sample_q, sample_d;
  logic signed [WORD_WIDTH-1:0] oldest_q, oldest_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic                         primed_q, primed_d;
  logic [15:0]                  overrun_q, overrun_d;
  logic                         timeout_err_q, timeout_err_d;
  logic [TMO_W-1:0]             tmo_cnt_q, tmo_cnt_d;
  logic signed [WORD_WIDTH-1:0] latch_q, latch_d;

  logic signed [WORD_WIDTH-1:0] ram_mem [FFT_SIZE];
  logic signed [WORD_WIDTH-1:0] ram_q;
  logic                         ram_we;
  logic                         ram_re;
  logic                         finish;

  // Drop counter saturates instead of wrapping so a long stall stays visible.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and datapath control for the accept/read/write/start/wait sequence.
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    oldest_d      = oldest_q;
    wr_ptr_d      = wr_ptr_q;
    primed_d      = primed_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;
    latch_d       = latch_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    finish        = 1'b0;

    // Any strobe arriving while not ready is lost, including the completion cycle.
    if (in_valid && !in_ready_q) begin
      overrun_d = sat_inc16(overrun_q);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          latch_d = in_sample;
          state_d = S_READ;
        end
      end
      S_READ: begin
        ram_re  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Until the window has filled once, the displaced sample is treated as zero.
        oldest_d = primed_q ? ram_q : '0;
        sample_d = latch_q;
        ram_we   = 1'b1;
        state_d  = S_START;
      end
      S_START: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (compute_done || (tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1))) begin
          finish = 1'b1;
          if (!compute_done) begin
            timeout_err_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A timed-out sweep still consumes its slot so the window stays aligned.
    if (finish) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (wr_ptr_q == PTR_W'(FFT_SIZE - 1)) begin
        primed_d = 1'b1;
      end
      state_d = S_IDLE;
    end

    in_ready_d = (state_d == S_IDLE);
    start_d    = (state_d == S_START);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      start_q       <= 1'b0;
      sample_q      <= '0;
      oldest_q      <= '0;
      wr_ptr_q      <= '0;
      primed_q      <= 1'b0;
      overrun_q     <= '0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      start_q       <= start_d;
      sample_q      <= sample_d;
      oldest_q      <= oldest_d;
      wr_ptr_q      <= wr_ptr_d;
      primed_q      <= primed_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  // Captured input sample; pure data, not reset.
  always_ff @(posedge clk) begin
    latch_q <= latch_d;
  end

  // Single-port sample RAM: synchronous read in READ, write in WRITE, same address.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[wr_ptr_q] <= latch_q;
    end
    if (ram_re) begin
      ram_q <= ram_mem[wr_ptr_q];
    end
  end

  assign in_ready      = in_ready_q;
  assign start_compute = start_q;
  assign sample        = sample_q;
  assign oldest_sample = oldest_q;
  assign wr_ptr        = wr_ptr_q;
  assign primed        = primed_q;
  assign overrun_count = overrun_q;
  assign timeout_err   = timeout_err_q;

endmodule
